pc_fetch_unit: RTL

Instruction-fetch stage directly upstream of the processor datapath, clocked by processor_clock. Owns the program counter and drives the imem address. Registers each fetched word into a fetch register for decode. Applies jump, branch and jr redirects signalled back from decode, and honours datapath stalls.

---
 rtl/pc_fetch_unit.sv | 95 +++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - instruction fetch stage: PC, fetch register, redirects, stall
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module pc_fetch_unit #(
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic [31:0]           imem_q,
    input  logic                  redir_j,
    input  logic [26:0]           j_target,
    input  logic                  redir_br,
    input  logic [16:0]           br_imm,
    input  logic                  redir_jr,
    input  logic [31:0]           jr_target,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    output logic [31:0]           link_pc,
    output logic [31:0]           fetch_cnt,
    output logic [31:0]           squash_cnt
);

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] target;
    logic [31:0]           br_sum;
    logic                  redirect;
    logic                  unused_bits;

    // A redirect only counts when it comes from a real instruction and the pipe is moving.
    assign redirect = instr_valid && !stall && (redir_jr || redir_j || redir_br);

    assign br_sum = 32'(instr_pc) + 32'd1 + {{15{br_imm[16]}}, br_imm};

    always_comb begin
        target = br_sum[ADDR_WIDTH-1:0];
        if (redir_jr) begin
            target = jr_target[ADDR_WIDTH-1:0];
        end else if (redir_j) begin
            target = j_target[ADDR_WIDTH-1:0];
        end
    end

    assign unused_bits = ^{j_target[26:ADDR_WIDTH], jr_target[31:ADDR_WIDTH], br_sum[31:ADDR_WIDTH]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (!stall) begin
            if (redirect) begin
                pc          <= target;
                instr       <= '0;
                instr_valid <= 1'b0;
            end else begin
                instr       <= imem_q;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
                pc          <= pc + 1'b1;
            end
        end
    end

    assign imem_addr = pc;
    assign link_pc   = 32'(instr_pc) + 32'd1;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_q;
    logic [31:0] squash_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_q  <= '0;
            squash_q <= '0;
        end else if (!stall) begin
            if (redirect) begin
                squash_q <= squash_q + 32'd1;
            end else begin
                fetch_q <= fetch_q + 32'd1;
            end
        end
    end

    assign fetch_cnt  = fetch_q;
    assign squash_cnt = squash_q;
`else
    assign fetch_cnt  = '0;
    assign squash_cnt = '0;
`endif

endmodule
